layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
// Initiator side of the per-layer start/done handshake. Holds a small per-layer type table
// and walks the network layer by layer. For each layer it pulses start to the selected
// engine controller (conv, pool or dense), waits for that engine's done pulse, then issues
// the next layer. Sits between the top-level run control and the layer controllers.
// PARAMETERS
// MAX_LAYERS  16    depth of the layer type table
// N_ENG       3     engine count; index 0=conv, 1=pool, 2=dense
// TIMEOUT     1024  max WAIT cycles per layer before a timeout error (>=2)
// PORTS
// clk         in   1                     clock, all logic on posedge
// rst         in   1                     asynchronous reset, active-high
// cfg_we      in   1                     write cfg_type into table[cfg_addr]; ignored while busy
// cfg_addr    in   $clog2(MAX_LAYERS)    table write index
// cfg_type    in   2                     0 conv, 1 pool, 2 dense, 3 reserved/illegal
// num_layers  in   $clog2(MAX_LAYERS+1)  layer count, sampled when run is accepted
// run         in   1                     one-cycle request to execute the table
// eng_start   out  N_ENG                 one-hot, one-cycle start pulse to the engine
// eng_done    in   N_ENG                 one-cycle done pulses from the engines
// cur_layer   out  $clog2(MAX_LAYERS)    index of the layer in progress
// busy        out  1                     high from run accept until run_done
// run_done    out  1                     one-cycle pulse at end of sequence, pass or fail
// err         out  1                     sticky error flag, cleared on the next accepted run
// err_code    out  2                     0 none, 1 illegal type, 2 spurious done, 3 timeout
// BEHAVIOUR
// - Reset (async): state IDLE, table entries=0, all outputs 0. Any in-flight eng_start
//   drops immediately. Nothing resumes after reset.
// - All outputs are registered.
// - FSM states: IDLE, ISSUE, WAIT, FINISH.
//   - IDLE:
//     - run=1 and num_layers=0: FINISH.
//     - run=1 and num_layers>0: latch N=num_layers (values >MAX_LAYERS clamp to MAX_LAYERS),
//       cur_layer=0, clear err/err_code, then ISSUE.
//   - ISSUE:
//     - table[cur_layer]==3: err=1, code=1, no start, then FINISH.
//     - Otherwise eng_start[type]=1 for exactly this cycle, timer=0, then WAIT.
//     - Any eng_done seen in ISSUE: err=1, code=2, then FINISH.
//   - WAIT: timer increments each cycle.
//     - Any eng_done bit other than the expected one: err=1, code=2, then FINISH.
//       This wins even if the expected done is high in the same cycle.
//     - Expected done with cur_layer==N-1: FINISH.
//     - Expected done otherwise: cur_layer+1, then ISSUE.
//     - timer reaches TIMEOUT-1 with no done: err=1, code=3, then FINISH.
//   - FINISH: run_done=1 for one cycle, then IDLE.
// - busy: 1 in ISSUE and WAIT; 0 in IDLE and FINISH.
// - Timing:
//   - run high in cycle c -> first eng_start in cycle c+1.
//   - Expected done in cycle d -> next eng_start in cycle d+1, or run_done in d+1 for the last layer.
//   - eng_done is sampled starting the cycle after eng_start, so an engine answering one cycle
//     after start is supported.
// - run while busy or during FINISH: ignored.
// - cfg_we while busy: ignored; while idle: takes effect next cycle.
// - eng_done seen in IDLE or FINISH: ignored, no error.
// - cur_layer holds its last value after FINISH until the next accepted run.
// TESTING
// - T1: table={0,1,2}, N=3, run@0, each engine done 1 cycle after start ->
//   eng_start=001@1, 010@3, 100@5; run_done@7; err=0.
// - T2: N=0, run@0 -> run_done@1, eng_start never asserted, busy stays 0.
// - T3: table={2,3}, N=2 -> dense start@1, done@2; run_done@4 with err=1, code=1;
//   no second start.
// - T4: table={0}, pool done pulses while waiting on conv -> err=1, code=2,
//   run_done next cycle.
// - T5: TIMEOUT=16, engine silent -> after 16 WAIT cycles err=1, code=3, run_done; busy low.
// - T6: rst high mid-WAIT at layer 2 -> outputs 0 at once. After release, run restarts
//   at layer 0 with the table contents reset to 0.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a per-layer engine-type table, issuing one start per layer and awaiting that engine's done.
module layer_sequencer #(
  parameter int MAX_LAYERS = 16,
  parameter int N_ENG      = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0]   cfg_addr,
  input  logic [1:0]                      cfg_type,
  input  logic [$clog2(MAX_LAYERS+1)-1:0] num_layers,
  input  logic                            run,
  output logic [N_ENG-1:0]                eng_start,
  input  logic [N_ENG-1:0]                eng_done,
  output logic [$clog2(MAX_LAYERS)-1:0]   cur_layer,
  output logic                            busy,
  output logic                            run_done,
  output logic                            err,
  output logic [1:0]                      err_code
);
  localparam int LW = $clog2(MAX_LAYERS);
  localparam int NW = $clog2(MAX_LAYERS+1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  state_t state, state_n;
  logic [MAX_LAYERS-1:0][1:0] tbl;
  logic [LW-1:0] last, last_n, layer_n;
  logic [TW-1:0] timer, timer_n;
  logic err_n;
  logic [1:0] code_n, cur_type, nxt_type;
  logic [N_ENG-1:0] exp_done, start_n;
  assign cur_type = tbl[cur_layer];
  assign nxt_type = tbl[layer_n];
  assign exp_done = N_ENG'(1) << cur_type;
  // start is registered, so it is decoded from the layer about to enter ISSUE
  assign start_n  = (state_n == ISSUE && nxt_type != 2'd3) ? N_ENG'(1) << nxt_type : '0;
  always_comb begin
    state_n = state;
    layer_n = cur_layer;
    last_n  = last;
    timer_n = timer;
    err_n   = err;
    code_n  = err_code;
    case (state)
      IDLE: if (run) begin
        if (num_layers == '0) state_n = FINISH;
        else begin
          state_n = ISSUE;
          layer_n = '0;
          last_n  = (num_layers > NW'(MAX_LAYERS)) ? LW'(MAX_LAYERS-1) : LW'(num_layers - 1'b1);
          err_n   = 1'b0;
          code_n  = 2'd0;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
        if (cur_type == 2'd3) begin
          state_n = FINISH;
          err_n   = 1'b1;
          code_n  = 2'd1;
        end else if (|eng_done) begin
          state_n = FINISH;
          err_n   = 1'b1;
          code_n  = 2'd2;
        end
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        if (|(eng_done & ~exp_done)) begin
          state_n = FINISH;
          err_n   = 1'b1;
          code_n  = 2'd2;
        end else if (|(eng_done & exp_done)) begin
          state_n = (cur_layer == last) ? FINISH : ISSUE;
          layer_n = (cur_layer == last) ? cur_layer : cur_layer + 1'b1;
        end else if (timer == TW'(TIMEOUT-1)) begin
          state_n = FINISH;
          err_n   = 1'b1;
          code_n  = 2'd3;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tbl       <= '0;
      cur_layer <= '0;
      last      <= '0;
      timer     <= '0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      eng_start <= '0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      state     <= state_n;
      cur_layer <= layer_n;
      last      <= last_n;
      timer     <= timer_n;
      err       <= err_n;
      err_code  <= code_n;
      eng_start <= start_n;
      busy      <= state_n == ISSUE || state_n == WAIT;
      run_done  <= state_n == FINISH;
      if (cfg_we && !busy) tbl[cfg_addr] <= cfg_type;
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: random and directed runs; a table-walking reference model fills a scoreboard checked by a monitor.
module tb_layer_sequencer;
  localparam int OK = 0, SP = 1, SL = 2;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, run = 1'b0;
  logic [3:0] cfg_addr = '0, cur_layer;
  logic [1:0] cfg_type = '0, err_code;
  logic [4:0] num_layers = '0;
  logic [2:0] eng_start, eng_done = '0;
  logic busy, run_done, err;
  typedef struct packed {
    logic       is_done;
    logic [2:0] start;
    logic       chk_err;
    logic       err;
    logic [1:0] code;
    logic       chk_layer;
    logic [3:0] layer;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0;
  int beh[16], dly[16];
  bit both[16];
  logic [1:0] tbl_m[16];
  int g;
  layer_sequencer #(.MAX_LAYERS(16), .N_ENG(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_type(cfg_type),
    .num_layers(num_layers), .run(run), .eng_start(eng_start), .eng_done(eng_done),
    .cur_layer(cur_layer), .busy(busy), .run_done(run_done), .err(err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask
  function automatic int push_done(input int er, input int cd, input int ly);
    exp_t e = '0;
    e.is_done = 1'b1;
    e.chk_err = 1'b1;
    e.err = 1'(er);
    e.code = 2'(cd);
    e.chk_layer = 1'b1;
    e.layer = 4'(ly);
    q.push_back(e);
    return er;
  endfunction
  // reference: expected events of one run; returns err after the run or -1 when unspecified
  function automatic int model(input int n);
    int nn = n > 16 ? 16 : n;
    exp_t e;
    if (nn == 0) begin
      e = '0;
      e.is_done = 1'b1;
      q.push_back(e);
      return -1;
    end
    for (int i = 0; i < nn; i++) begin
      if (tbl_m[i] == 2'd3) return push_done(1, 1, i);
      e = '0;
      e.start = 3'd1 << tbl_m[i];
      q.push_back(e);
      if (beh[i] == SP) return push_done(1, 2, i);
      if (beh[i] == SL) return push_done(1, 3, i);
    end
    return push_done(0, 0, nn - 1);
  endfunction
  always @(negedge clk) begin
    if (!rst && (eng_start != 3'b0 || run_done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: eng_start=%b run_done=%b with empty scoreboard", eng_start, run_done);
      end else begin
        me = q.pop_front();
        chk("event_kind", int'(run_done), int'(me.is_done));
        if (me.is_done) begin
          chk("busy_at_done", int'(busy), 0);
          if (me.chk_err) begin
            chk("err", int'(err), int'(me.err));
            chk("err_code", int'(err_code), int'(me.code));
          end
          if (me.chk_layer) chk("cur_layer", int'(cur_layer), int'(me.layer));
        end else begin
          chk("eng_start", int'(eng_start), int'(me.start));
          chk("busy_at_start", int'(busy), 1);
        end
      end
    end
  end
  task automatic cfg_write(input int a, input int t);
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_type = 2'(t);
    @(negedge clk);
    cfg_we = 1'b0;
    tbl_m[a] = 2'(t);
  endtask
  task automatic run_seq(input int n);
    int nn, li, gg, cnt, ee;
    logic [2:0] s;
    nn = n > 16 ? 16 : n;
    li = 0;
    gg = 0;
    ee = model(n);
    num_layers = 5'(n);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    if (!(nn > 0 && tbl_m[0] == 2'd3)) chk("first_latency", int'(eng_start != 3'b0 || run_done), 1);
    while (!run_done && gg < 200) begin
      if (eng_start != 3'b0) begin
        s = eng_start;
        if (beh[li] == OK) begin
          cfg_we = 1'b1;
          cfg_addr = 4'($urandom);
          cfg_type = 2'($urandom);
          repeat (dly[li]) begin
            @(negedge clk);
            cfg_we = 1'b0;
          end
          eng_done = s;
          @(negedge clk);
          eng_done = 3'b0;
          chk("advance", int'(eng_start != 3'b0 || run_done), int'(!(li + 1 < nn && tbl_m[li+1] == 2'd3)));
        end else if (beh[li] == SP) begin
          repeat (dly[li]) @(negedge clk);
          eng_done = {s[1:0], s[2]} | (both[li] ? s : 3'b0);
          @(negedge clk);
          eng_done = 3'b0;
          chk("spurious_end", int'(run_done), 1);
        end else begin
          cnt = 0;
          while (!run_done && cnt < 40) begin
            @(negedge clk);
            cnt++;
          end
          chk("timeout_len", cnt, TO + 1);
        end
        li++;
      end else begin
        @(negedge clk);
        gg++;
      end
    end
    chk("run_done_seen", int'(run_done), 1);
    @(negedge clk);
    chk("run_done_pulse", int'(run_done), 0);
    if (ee >= 0) chk("err_sticky", int'(err), ee);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    int r;
    for (int i = 0; i < 16; i++) begin
      tbl_m[i] = 2'd0;
      beh[i] = OK;
      dly[i] = 1;
      both[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_eng_start", int'(eng_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_run_done", int'(run_done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_cur_layer", int'(cur_layer), 0);
    @(negedge clk);
    cfg_write(0, 0);
    cfg_write(1, 1);
    cfg_write(2, 2);
    run_seq(3);
    eng_done = 3'b111;
    @(negedge clk);
    eng_done = 3'b000;
    @(negedge clk);
    chk("idle_done_err", int'(err), 0);
    chk("idle_done_busy", int'(busy), 0);
    run_seq(0);
    cfg_write(0, 2);
    cfg_write(1, 3);
    run_seq(2);
    cfg_write(0, 0);
    beh[0] = SP;
    dly[0] = 2;
    run_seq(1);
    beh[0] = SL;
    run_seq(1);
    beh[0] = OK;
    dly[0] = 1;
    for (int i = 0; i < 3; i++) cfg_write(i, 1);
    for (int k = 0; k < 3; k++) begin
      e = '0;
      e.start = 3'b010;
      q.push_back(e);
    end
    num_layers = 5'd3;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      g = 0;
      while (eng_start == 3'b0 && g < 50) begin
        @(negedge clk);
        g++;
      end
      chk("t6_start", int'(eng_start), 2);
      if (k < 2) begin
        @(negedge clk);
        eng_done = 3'b010;
        @(negedge clk);
        eng_done = 3'b000;
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_cur_layer", int'(cur_layer), 0);
    chk("t6_eng_start", int'(eng_start), 0);
    chk("t6_run_done", int'(run_done), 0);
    chk("t6_err", int'(err), 0);
    q.delete();
    for (int i = 0; i < 16; i++) tbl_m[i] = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seq(1);
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 4);
      for (int w = 0; w < r; w++) cfg_write($urandom_range(0, 15), ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 99);
        beh[i] = r < 88 ? OK : (r < 94 ? SP : SL);
        dly[i] = $urandom_range(1, 4);
        both[i] = 1'($urandom_range(0, 1));
      end
      run_seq($urandom_range(0, 17));
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
